pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised successor to the fixed-width ripple adder: a WIDTH-bit adder split into SLICE_W-bit slices, with one pipeline register stage per slice.
- Each carry crosses one stage per cycle, so the critical path is one SLICE_W-bit add regardless of WIDTH.
- Valid/ready handshake on both sides with full backpressure; throughput is 1 op/cycle.
- Used wherever wide additions must meet timing in the datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- SLICE_W, 8, bits added per pipeline stage.
- Derived constraint: WIDTH % SLICE_W == 0. Violation is an elaboration-time error.
- STAGES is a derived localparam, not a parameter: STAGES = WIDTH/SLICE_W. This is also the latency.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input operation valid.
- ready_o  output  1  block can accept an operation this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- carry_i  input  1  carry-in.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- sum_o  output  WIDTH  a + b + carry_i, modulo 2^WIDTH.
- carry_o  output  1  unsigned carry-out of the MSB.
- overflow_o  output  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - all stage valid bits cleared and all data registers zeroed;
  - valid_o=0, sum_o=0, carry_o=0, overflow_o=0, ready_o=1.
  - Reset mid-operation discards every in-flight op; no partial result is ever presented.
- Acceptance: an op is accepted on a rising edge where valid_i && ready_o.
- Stage k (0..STAGES-1):
  - adds slice k of A and B with the carry registered by stage k-1 (carry_i for stage 0);
  - registers the slice-k sum bits and the slice carry;
  - carries forward the already-computed lower sum bits;
  - carries forward the not-yet-added upper operand bits.
- Output: the last stage's registers drive sum_o/carry_o/overflow_o/valid_o directly; there is no combinational path from a_i/b_i to the outputs.
- Latency: a result accepted at edge N is presented with valid_o=1 after edge N+STAGES-1, provided there is no stall.
- Flow control:
  - stage k advances when !v[k] || ready[k+1], where ready[STAGES] = ready_i;
  - ready_o = !v[0] || ready[1]. This combinational ready chain permits 1 op/cycle.
- Backpressure:
  - with ready_i=0, the pipeline fills and then ready_o=0 once all STAGES stages hold data;
  - held outputs stay stable while valid_o && !ready_i;
  - no op is lost, duplicated or reordered.
- Simultaneous events: an output drain and an input accept in the same cycle while full are legal and sustain 1 op/cycle.
- Bubbles: a stage with v[k]=0 takes new data whenever it is offered, and bubbles collapse.
- Wrap-around: 0xFFFF_FFFF+1 gives sum 0, carry_o=1, overflow_o=0.
- Inputs are don't-care when valid_i=0.

Optional Feature:
- Macro PIPELINED_ADDER_SUB_EN.
- When defined:
  - extra port sub_i (input, 1 bit, sampled with the op);
  - sub_i=1 computes a + ~b + 1 and ignores carry_i;
  - carry_o=1 means no borrow, i.e. a >= b unsigned;
  - overflow_o is the signed subtraction overflow.
- When undefined: no sub_i port, add only, and the logic is identical to the add path.

Decomposition:
- Package pipelined_adder_pkg holds:
  - the typedef for a stage record (valid, partial sum, carry, remaining A/B, sub flag);
  - a function that validates the WIDTH/SLICE_W combination.
- One sub-module, pipelined_adder_slice: a combinational SLICE_W-bit add with carry-in and carry-out, exposing the MSB carry-in for overflow.
  - It is instantiated STAGES times via generate; the register stages live in the top module.

Test Plan:
All scenarios use WIDTH=32, SLICE_W=8, STAGES=4.
1. Single ops:
   - a=0xFFFFFFFF, b=1, carry_i=0, ready_i=1 -> 4 cycles later: sum_o=0, carry_o=1, overflow_o=0.
   - a=0x7FFFFFFF, b=1 -> sum_o=0x80000000, carry_o=0, overflow_o=1.
2. Back-to-back streaming: 16 random ops with valid_i and ready_i held high -> results in order, one per cycle, the first 4 cycles after the first accept; compare against a reference model.
3. Backpressure:
   - valid_i=1 continuously, ready_i=0 for 10 cycles -> exactly 4 ops accepted, then ready_o=0, and the outputs hold stable;
   - release ready_i -> all ops emerge in order with no gaps or duplicates.
4. Random stalls: random valid_i/ready_i at 50% each for 1000 ops -> scoreboard match, no loss or reorder.
5. Reset mid-stream: rst_ni pulsed low while 3 ops are in flight -> valid_o=0 immediately (asynchronous), ready_o=1, and no stale result after release.
6. Subtract mode (macro defined): a=5, b=7, sub_i=1 -> sum_o=0xFFFFFFFE, carry_o=0; a=7, b=5, sub_i=1 -> sum_o=2, carry_o=1.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
// The stage control record below is width-independent, so it can live here.
// The top module wraps it with its WIDTH-dependent data fields.
// Optional subtract mode is enabled by defining PIPELINED_ADDER_SUB_EN.
package pipelined_adder_pkg;

    // Per-stage control bits carried down the pipeline next to the data.
    typedef struct packed {
        logic valid;  // stage holds a live operation
        logic carry;  // carry out of the slice this stage added
        logic ovf;    // signed overflow; meaningful in the last stage only
        logic sub;    // operation is a subtraction (B inverted, carry-in 1)
    } stage_ctrl_t;

    // A WIDTH/SLICE_W pair is usable only if the slices tile the word exactly.
    function automatic bit cfg_is_valid(input int width, input int slice_w);
        return (width > 0) && (slice_w > 0) && ((width % slice_w) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational SLICE_W-bit adder with carry-in and carry-out.
// Also exposes the carry into the slice MSB, used for signed overflow.
module pipelined_adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               carry_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               carry_o,
    output logic               msb_carry_o
);

    // Slice sum; the MSB carry-in is recovered as a ^ b ^ sum at the MSB.
    always_comb begin
        {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, carry_i};
        msb_carry_o      = a_i[SLICE_W-1] ^ b_i[SLICE_W-1] ^ sum_o[SLICE_W-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into SLICE_W-bit slices, one register stage per slice.
// Each stage adds its own slice using the carry registered by the stage before.
// So the critical path is one slice add, and the latency is STAGES cycles.
// Valid/ready on both sides. The ready chain is combinational, giving 1 op/cycle.
// Define PIPELINED_ADDER_SUB_EN to add the sub_i port, which selects a + ~b + 1.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int STAGES = WIDTH / SLICE_W;

    if (!cfg_is_valid(WIDTH, SLICE_W)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of SLICE_W");
    end

    // Full stage record. The sum holds the slices added so far.
    // a and b hold the raw operands; later stages read their upper slices.
    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    logic [STAGES-1:0] stage_valid;
    logic [STAGES:0]   stage_ready;  // stage_ready[k]: stage k may load this cycle
    logic              sub_in;

`ifdef PIPELINED_ADDER_SUB_EN
    assign sub_in = sub_i;
`else
    assign sub_in = 1'b0;
`endif

    // Stage k can load when it, or some stage downstream of it, has room.
    // Equivalently, when ready_i is high or the tail from k is not full.
    // Written without a self-referencing chain so it stays a clean comb cone.
    always_comb begin
        logic tail_full;
        stage_ready         = '0;
        stage_ready[STAGES] = ready_i;
        for (int k = 0; k < STAGES; k++) begin
            tail_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                tail_full = tail_full & stage_valid[j];
            end
            stage_ready[k] = ready_i | ~tail_full;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t             in_s;     // record offered to this stage
        stage_t             stage_d;  // record after this stage's slice add
        stage_t             q;
        logic [SLICE_W-1:0] slice_sum;
        logic               slice_carry;
        logic               msb_carry;

        if (k == 0) begin : g_head
            // Stage 0 is fed from the ports. Subtraction forces a carry-in of 1.
            always_comb begin
                // NOTE: the whole record gets a default first, so every field is driven on every path and no latch is inferred.
                in_s            = '0;
                in_s.ctrl.valid = valid_i;
                in_s.ctrl.sub   = sub_in;
                in_s.ctrl.carry = sub_in | carry_i;
                in_s.a          = a_i;
                in_s.b          = b_i;
            end
        end else begin : g_body
            assign in_s = g_stage[k-1].q;
        end

        pipelined_adder_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a_i         (in_s.a[k*SLICE_W +: SLICE_W]),
            .b_i         (in_s.b[k*SLICE_W +: SLICE_W] ^ {SLICE_W{in_s.ctrl.sub}}),
            .carry_i     (in_s.ctrl.carry),
            .sum_o       (slice_sum),
            .carry_o     (slice_carry),
            .msb_carry_o (msb_carry)
        );

        // Merge this slice's result into the record moving down the pipe.
        always_comb begin
            stage_d                         = in_s;
            stage_d.sum[k*SLICE_W +: SLICE_W] = slice_sum;
            stage_d.ctrl.carry              = slice_carry;
            stage_d.ctrl.ovf                = (k == STAGES - 1) ? (msb_carry ^ slice_carry) : 1'b0;
        end

        // Stage register: load a live op, collapse a bubble, or hold when stalled.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                // NOTE: the data fields are reset along with valid, so the outputs read zero out of reset rather than stale X.
                q <= '0;
            end else if (stage_ready[k]) begin
                // NOTE: non-blocking, so each stage samples its neighbour's value from before this edge.
                if (in_s.ctrl.valid) begin
                    q <= stage_d;
                end else begin
                    q.ctrl.valid <= 1'b0;
                end
            end
        end

        assign stage_valid[k] = q.ctrl.valid;
    end

    assign ready_o    = stage_ready[0];
    assign valid_o    = g_stage[STAGES-1].q.ctrl.valid;
    assign sum_o      = g_stage[STAGES-1].q.sum;
    assign carry_o    = g_stage[STAGES-1].q.ctrl.carry;
    assign overflow_o = g_stage[STAGES-1].q.ctrl.ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, SLICE_W=8, 4 stages).
// A queue-based reference model computes each result with plain wide arithmetic.
// Subtract checks run when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;

    localparam int W      = 32;
    localparam int STAGES = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          carry_i = 1'b0;
    logic          sub_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  sum_o;
    logic          carry_o;
    logic          overflow_o;

    pipelined_adder #(
        .WIDTH   (W),
        .SLICE_W (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .carry_i    (carry_i),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub_i      (sub_i),
`endif
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sum_o      (sum_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc_edge;
    } exp_t;

    // Reference: a + b + cin (or a - b) on a 33-bit word. Signed overflow is
    // two same-signed addends whose result has the other sign.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t          r;
        logic [W-1:0]  bb;
        logic [W:0]    full;
        bb         = sub ? ~b : b;
        full       = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.sum      = full[W-1:0];
        r.carry    = full[W];
        r.ovf      = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
        r.acc_edge = 0;
        return r;
    endfunction

    // ---------------- monitor / scoreboard (samples on falling edge) ----------
    exp_t          exp_q[$];
    int            cyc = 0;
    int            acc_cnt = 0;
    bit            strict_lat = 1'b0;
    bit            held_vld = 1'b0;
    logic [W+1:0]  held_val;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) check("hold_stable", {carry_o, overflow_o, sum_o}, held_val);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("out_without_op", valid_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {carry_o, overflow_o, sum_o}, {e.carry, e.ovf, e.sum});
                    if (strict_lat) check("latency", cyc - e.acc_edge, STAGES - 1);
                end
            end
            if (valid_i && ready_o) begin
                e = model(a_i, b_i, carry_i, sub_i);
                e.acc_edge = cyc + 1;
                exp_q.push_back(e);
                acc_cnt++;
            end
            held_vld = valid_o && !ready_i;
            held_val = {carry_o, overflow_o, sum_o};
        end
    end

    // ---------------- driver helpers ----------------
    logic [W-1:0] corners [6];
    initial corners = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_0000};

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rnd_op();
        a_i     = rnd_word();
        b_i     = rnd_word();
        carry_i = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDER_SUB_EN
        sub_i   = 1'($urandom_range(0, 1));
`endif
    endtask

    // Issue one op and wait (bounded) for its result; checks the values there.
    task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub,
                             input logic [W-1:0] x_sum, input logic x_c, input logic x_v);
        bit seen = 1'b0;
        a_i = a; b_i = b; carry_i = cin; sub_i = sub; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (valid_o) begin
                seen = 1'b1;
                check({tag, "_sum"}, sum_o, x_sum);
                check({tag, "_carry"}, carry_o, x_c);
                check({tag, "_ovf"}, overflow_o, x_v);
            end
        end
        if (!seen) check({tag, "_timeout"}, valid_o, 1'b1);
        step();
        sub_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int acc0;

        // Reset state
        #12;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_outputs", {carry_o, overflow_o, sum_o}, '0);
        step();
        rst_ni = 1'b1;
        ready_i = 1'b1;
        step();

        // Single ops: wrap-around and signed overflow
        single_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        single_op("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single_op("cin",  32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SUB_EN
        single_op("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
`endif
        drain("single");

        // Back-to-back streaming: 16 ops, exact latency enforced
        strict_lat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rnd_op();
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        drain("stream");
        strict_lat = 1'b0;

        // Backpressure: fill with ready_i low, then release
        ready_i = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            rnd_op();
            valid_i = 1'b1;
            step();
        end
        check("bp_accepts", acc_cnt - acc0, STAGES);
        @(negedge clk_i);
        check("bp_ready_low", ready_o, 1'b0);
        check("bp_valid_held", valid_o, 1'b1);
        step();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_drain_valid", valid_o, (i < STAGES));
        end
        step();
        drain("bp");

        // Random valid/ready at 50% each until 1000 ops accepted
        acc0 = acc_cnt;
        for (int i = 0; i < 20000 && (acc_cnt - acc0) < 1000; i++) begin
            rnd_op();
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            step();
        end
        check("rand_accepted", (acc_cnt - acc0) >= 1000, 1'b1);
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain("rand");

        // Reset mid-stream with 3 ops in flight, one already at the output
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_op();
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        step();
        check("pre_rst_valid_o", valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid_o", valid_o, 1'b0);
        check("midrst_ready_o", ready_o, 1'b1);
        check("midrst_outputs", {carry_o, overflow_o, sum_o}, '0);
        step();
        step();
        rst_ni = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check("post_rst_no_stale", valid_o, 1'b0);
            step();
        end

        // Pipeline still works after reset
        single_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
